// File: rtl/f2sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : f2sdram_pkg
//  Description : Shared types and constants for the f2sdram burst writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package f2sdram_pkg;

    // Writer control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_BURST     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Widest byteenable supported (1024-bit data); users slice the low bits.
    localparam int C_MAX_BYTEENABLE_WIDTH = 128;
    localparam logic [C_MAX_BYTEENABLE_WIDTH-1:0] C_BYTEENABLE_ONES = '1;

endpackage
`default_nettype wire

// File: rtl/f2sdram_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : f2sdram_sync_fifo
//  Description : Single-clock show-ahead FIFO with occupancy count. The head
//                word is visible on head_data whenever count is non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module f2sdram_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]    C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is dropped even if a pop happens the same cycle.
    assign w_push    = push && (r_count != C_DEPTH);
    assign w_pop     = pop  && (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == C_DEPTH);
    assign count     = r_count;

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/f2sdram_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : f2sdram_burst_writer
//  Description : Converts a (word address, word count) command plus a write
//                data stream into Avalon-MM write bursts of up to MAX_BURST
//                beats. A burst is only started once every beat is buffered,
//                so avm_write never deasserts mid-burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module f2sdram_burst_writer
    import f2sdram_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int MAX_BURST        = 16,
    parameter int LENGTH_WIDTH     = 16,
    localparam int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    localparam int ADDRESS_WIDTH    = 32 - $clog2(BYTEENABLE_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]     cmd_address,
    input  logic [LENGTH_WIDTH-1:0]      cmd_length,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         busy,
    output logic                         done,
    input  logic                         avm_waitrequest,
    output logic [BURSTCOUNT_WIDTH-1:0]  avm_burstcount,
    output logic [ADDRESS_WIDTH-1:0]     avm_address,
    output logic [DATA_WIDTH-1:0]        avm_writedata,
    output logic [BYTEENABLE_WIDTH-1:0]  avm_byteenable,
    output logic                         avm_write
);

    localparam int                          FIFO_DEPTH  = 2 * MAX_BURST;
    localparam int                          FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LENGTH_WIDTH-1:0]     C_MAX_BURST = LENGTH_WIDTH'(MAX_BURST);
    localparam logic [BURSTCOUNT_WIDTH-1:0] C_ONE_BEAT  = BURSTCOUNT_WIDTH'(1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic [ADDRESS_WIDTH-1:0]     r_address;
    logic [LENGTH_WIDTH-1:0]      r_remaining;
    logic [BURSTCOUNT_WIDTH-1:0]  r_burst_len;
    logic [BURSTCOUNT_WIDTH-1:0]  r_beat_cnt;
    logic [LENGTH_WIDTH-1:0]      w_burst_len_full;
    logic [BURSTCOUNT_WIDTH-1:0]  w_burst_len;
    logic [LENGTH_WIDTH-1:0]      w_rem_after;
    logic                         w_data_ready;
    logic                         w_beat;
    logic                         w_last_beat;
    logic [DATA_WIDTH-1:0]        w_fifo_head;
    logic                         w_fifo_full;
    logic [FIFO_CNT_W-1:0]        w_fifo_count;

    f2sdram_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (w_beat),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    // Next burst is the smaller of what is left and MAX_BURST.
    assign w_burst_len_full = (r_remaining > C_MAX_BURST) ? C_MAX_BURST : r_remaining;
    assign w_burst_len      = BURSTCOUNT_WIDTH'(w_burst_len_full);
    assign w_data_ready     = 32'(w_fifo_count) >= 32'(w_burst_len);
    assign w_rem_after      = r_remaining - LENGTH_WIDTH'(r_burst_len);
    assign w_beat           = (r_state == ST_BURST) && !avm_waitrequest;
    assign w_last_beat      = w_beat && (r_beat_cnt == (r_burst_len - C_ONE_BEAT));

    assign cmd_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign avm_write      = (r_state == ST_BURST);
    assign avm_burstcount = r_burst_len;
    assign avm_address    = r_address;
    assign avm_writedata  = w_fifo_head;
    assign avm_byteenable = avm_write ? C_BYTEENABLE_ONES[BYTEENABLE_WIDTH-1:0] : '0;
    assign in_ready       = !w_fifo_full;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_next = (cmd_length == '0) ? ST_DONE : ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (w_data_ready) w_state_next = ST_BURST;
            end
            ST_BURST: begin
                if (w_last_beat) w_state_next = (w_rem_after == '0) ? ST_DONE : ST_WAIT_DATA;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, burst sizing and beat/address bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address   <= '0;
            r_remaining <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_address   <= cmd_address;
                        r_remaining <= cmd_length;
                        r_beat_cnt  <= '0;
                    end
                end
                ST_WAIT_DATA: begin
                    r_burst_len <= w_burst_len;
                    r_beat_cnt  <= '0;
                end
                ST_BURST: begin
                    if (w_last_beat) begin
                        r_beat_cnt  <= '0;
                        r_address   <= r_address + ADDRESS_WIDTH'(r_burst_len);
                        r_remaining <= w_rem_after;
                    end else if (w_beat) begin
                        r_beat_cnt  <= r_beat_cnt + C_ONE_BEAT;
                    end
                end
                default: begin
                    r_beat_cnt <= r_beat_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_f2sdram_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f2sdram_burst_writer
//  Description : Self-checking bench: a queue-based model of buffered data and
//                expected bursts is compared with the Avalon master every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_f2sdram_burst_writer;

    localparam int AW = 29;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_address = '0;
    logic [15:0]   cmd_length = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          busy;
    logic          done;
    logic          avm_waitrequest = 1'b0;
    logic [7:0]    avm_burstcount;
    logic [AW-1:0] avm_address;
    logic [63:0]   avm_writedata;
    logic [7:0]    avm_byteenable;
    logic          avm_write;

    always #5 clk = ~clk;

    f2sdram_burst_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_address     (cmd_address),
        .cmd_length      (cmd_length),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .busy            (busy),
        .done            (done),
        .avm_waitrequest (avm_waitrequest),
        .avm_burstcount  (avm_burstcount),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model state ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    logic [63:0]   model_q[$];
    burst_t        exp_q[$];
    logic [AW-1:0] log_addr[$];
    int            log_len[$];
    int            beat_idx = 0;
    int            beats_total = 0;
    int            done_cnt = 0;
    int            rises = 0;
    int            write_cycles = 0;
    int            last_rise_size = 0;
    int            accept_cyc = 0;
    int            done_cyc = 0;
    int            cyc = 0;
    bit            prev_done = 0;
    bit            prev_write = 0;
    bit            wr_rand_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Random waitrequest generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = wr_rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Compare process: checks outputs and advances the model for the coming edge.
    always @(negedge clk) begin : compare
        bit            can_push;
        burst_t        b;
        logic [AW-1:0] a;
        int            rem;
        int            bl;
        if (!rst_n) begin
            chk("rst_write", avm_write, 0);
            chk("rst_burstcount", avm_burstcount, 0);
            chk("rst_address", avm_address, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_in_ready", in_ready, 1);
            model_q.delete();
            exp_q.delete();
            beat_idx   = 0;
            prev_done  = 0;
            prev_write = 0;
        end else begin
            can_push = model_q.size() < 32;
            chk("in_ready", in_ready, can_push);
            chk("byteenable", avm_byteenable, avm_write ? 64'hFF : 64'h0);
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            if (done) chk("done_one_cycle", prev_done, 0);
            if (avm_write) begin
                write_cycles++;
                if (!prev_write) begin
                    rises++;
                    last_rise_size = model_q.size();
                end
                chk("busy_in_burst", busy, 1);
                chk("write_has_command", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    b = exp_q[0];
                    chk("avm_address", avm_address, b.addr);
                    chk("avm_burstcount", avm_burstcount, b.len);
                    chk("beats_buffered", model_q.size() >= (int'(b.len) - beat_idx), 1);
                    if (model_q.size() != 0) chk("avm_writedata", avm_writedata, model_q[0]);
                    if (!avm_waitrequest) begin
                        if (model_q.size() != 0) model_q.delete(0);
                        beats_total++;
                        beat_idx++;
                        if (beat_idx == int'(b.len)) begin
                            log_addr.push_back(avm_address);
                            log_len.push_back(int'(avm_burstcount));
                            exp_q.delete(0);
                            beat_idx = 0;
                        end
                    end
                end
            end
            prev_write = avm_write;
            prev_done  = done;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                accept_cyc = cyc;
                rem = int'(cmd_length);
                a   = cmd_address;
                while (rem > 0) begin
                    bl     = (rem > 16) ? 16 : rem;
                    b.addr = a;
                    b.len  = 8'(bl);
                    exp_q.push_back(b);
                    a   = a + AW'(bl);
                    rem = rem - bl;
                end
            end
            if (in_valid && can_push) model_q.push_back(in_data);
        end
    end

    // ---------------- stimulus tasks (called at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input int gap);
        int sent = 0;
        int budget = 0;
        bit hs;
        logic [63:0] w;
        w = {$urandom, $urandom};
        while (sent < n && budget < 5000) begin
            in_valid = 1'b1;
            in_data  = w;
            @(negedge clk);
            hs = in_ready;
            tick();
            budget++;
            if (hs) begin
                sent++;
                w = {$urandom, $urandom};
                in_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        in_valid = 1'b0;
        if (sent < n) chk("push_timeout", sent, n);
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [15:0] len);
        int budget = 0;
        bit hs = 0;
        cmd_valid   = 1'b1;
        cmd_address = addr;
        cmd_length  = len;
        while (!hs && budget < 5000) begin
            @(negedge clk);
            hs = cmd_ready;
            tick();
            budget++;
        end
        cmd_valid = 1'b0;
        if (!hs) chk("cmd_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int budget = 0;
        bit ok = 0;
        while (!ok && budget < 5000) begin
            tick();
            budget++;
            ok = !busy && (exp_q.size() == 0);
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // 40 words at 0x1000: preload a full FIFO, feed the rest while bursting.
    task automatic run_basic();
        int l0 = log_addr.size();
        int d0 = done_cnt;
        int b0 = beats_total;
        push_words(32, 0);
        chk("preload_full_in_ready", in_ready, 0);
        fork
            push_words(8, 0);
            send_cmd(29'h1000, 16'd40);
        join
        wait_idle();
        chk("basic_burst_count", log_addr.size() - l0, 3);
        chk("basic_b0_addr", log_addr[l0], 29'h1000);
        chk("basic_b0_len", log_len[l0], 16);
        chk("basic_b1_addr", log_addr[l0+1], 29'h1010);
        chk("basic_b1_len", log_len[l0+1], 16);
        chk("basic_b2_addr", log_addr[l0+2], 29'h1020);
        chk("basic_b2_len", log_len[l0+2], 8);
        chk("basic_done_pulses", done_cnt - d0, 1);
        chk("basic_beats", beats_total - b0, 40);
    endtask

    initial begin : main
        int r0, w0, d0, b0, l0, len, budget, leftover;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        run_basic();

        // Trickled data: exactly one burst, started with all 16 words buffered.
        r0 = rises;
        w0 = write_cycles;
        send_cmd(29'h2000, 16'd16);
        push_words(16, 3);
        wait_idle();
        chk("trickle_bursts", rises - r0, 1);
        chk("trickle_write_cycles", write_cycles - w0, 16);
        chk("trickle_buffered_at_start", last_rise_size, 16);

        // Random waitrequest, random commands with surplus words carried over.
        wr_rand_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 50);
            fork
                push_words(len + $urandom_range(0, 3), $urandom_range(0, 2));
                send_cmd(AW'($urandom), 16'(len));
            join
            wait_idle();
        end
        l0 = log_addr.size();
        fork
            push_words(20, 0);
            send_cmd(29'h1FFF_FFF8, 16'd20);
        join
        wait_idle();
        chk("wrap_b0_addr", log_addr[l0], 29'h1FFF_FFF8);
        chk("wrap_b0_len", log_len[l0], 16);
        chk("wrap_b1_addr", log_addr[l0+1], 29'h0000_0008);
        chk("wrap_b1_len", log_len[l0+1], 4);
        leftover = model_q.size();
        send_cmd(29'h0ABC_0000, 16'(leftover));
        wait_idle();
        chk("surplus_drained", model_q.size(), 0);
        wr_rand_en = 1'b0;
        tick();

        // Zero-length command: a done pulse, no bus activity.
        d0 = done_cnt;
        w0 = write_cycles;
        send_cmd(29'h0123, 16'd0);
        wait_idle();
        chk("zero_done_pulses", done_cnt - d0, 1);
        chk("zero_done_latency", done_cyc - accept_cyc, 1);
        chk("zero_no_write", write_cycles - w0, 0);

        // Reset during the fifth beat of a 16-beat burst.
        b0 = beats_total;
        push_words(16, 0);
        send_cmd(29'h4000, 16'd16);
        budget = 0;
        while ((beats_total - b0) < 5 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        chk("reset_reach_beat5", beats_total - b0, 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_write", avm_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fifo_empty", in_ready, 1);
        chk("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_basic();

        // Full FIFO without command, then a 32-word command drains it.
        d0 = done_cnt;
        b0 = beats_total;
        push_words(32, 0);
        tick();
        chk("full_in_ready", in_ready, 0);
        send_cmd(29'h5000, 16'd32);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(avm_write && !avm_waitrequest) && budget < 1000);
        tick();
        chk("ready_after_first_pop", in_ready, 1);
        // A command offered while busy must be ignored.
        cmd_valid   = 1'b1;
        cmd_address = 29'h7777;
        cmd_length  = 16'd5;
        repeat (5) tick();
        cmd_valid = 1'b0;
        wait_idle();
        chk("drain_beats", beats_total - b0, 32);
        chk("drain_done_pulses", done_cnt - d0, 1);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
